// File: rtl/sdram_burst_read.sv
// SDRAM burst read engine.
// Accepts one read request at a time and issues ACTIVE -> READ -> PRECHARGE.
// Returns BURST_LEN words on a valid/last stream with no backpressure.
// The device mode register must already match CAS_LAT and BURST_LEN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; oready high
// ACT      | ACTIVE command on the bus (row + bank)
// RCD_WAIT | NOPs until T_RCD has elapsed after ACTIVE
// RD       | READ command on the bus (column + bank, A10 low)
// CAS_WAIT | NOPs until the first word reaches DRAM_DQ
// DATA     | one burst word on DRAM_DQ per cycle; captured at the edge
// PRE      | PRECHARGE ALL on the bus; last beat is presented here
// RP_WAIT  | NOPs until T_RP has elapsed after PRECHARGE
module sdram_burst_read #(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BANK_W    = 2,
  parameter int DATA_W    = 16,
  parameter int CAS_LAT   = 2,
  parameter int BURST_LEN = 4,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              ienb,
  input  logic              ireq,
  input  logic [ROW_W-1:0]  irow,
  input  logic [COL_W-1:0]  icolumn,
  input  logic [BANK_W-1:0] ibank,
  output logic              oready,
  output logic              ovalid,
  output logic [DATA_W-1:0] odata,
  output logic              olast,
  output logic              ofin,
  output logic              DRAM_CLK,
  output logic              DRAM_CKE,
  output logic [ROW_W-1:0]  DRAM_ADDR,
  output logic [BANK_W-1:0] DRAM_BA,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic              DRAM_LDQM,
  output logic              DRAM_UDQM,
  input  logic [DATA_W-1:0] DRAM_DQ
);

  // Parameter legality. A10 must exist on the address bus for PRECHARGE ALL.
  if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cas
    $error("sdram_burst_read: CAS_LAT must be 2 or 3");
  end
  if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_bl
    $error("sdram_burst_read: BURST_LEN must be 1, 2, 4 or 8");
  end
  if (T_RCD < 1) begin : g_bad_rcd
    $error("sdram_burst_read: T_RCD must be >= 1");
  end
  if (T_RP < 1) begin : g_bad_rp
    $error("sdram_burst_read: T_RP must be >= 1");
  end
  if (COL_W > 10 || COL_W > ROW_W) begin : g_bad_col
    $error("sdram_burst_read: COL_W must be <= 10 and <= ROW_W");
  end
  if (ROW_W < 11) begin : g_bad_row
    $error("sdram_burst_read: ROW_W must be >= 11 so that A10 exists");
  end

  localparam int MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int MAX_B = (CAS_LAT > BURST_LEN) ? CAS_LAT : BURST_LEN;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_PRE = 3'b010;

  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << 10;

  typedef enum logic [2:0] {
    IDLE,
    ACT,
    RCD_WAIT,
    RD,
    CAS_WAIT,
    DATA,
    PRE,
    RP_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q;
  logic [BANK_W-1:0]   bank_q;
  logic                valid_q;
  logic                last_q;
  logic                fin_q;
  logic [DATA_W-1:0]   data_q;
  logic                cke_q;
  logic                cs_n_q;
  logic [2:0]          cmd_q;
  logic [ROW_W-1:0]    addr_q;
  logic [BANK_W-1:0]   ba_q;
  logic                dqm_q;
  logic                accept;

  // Acceptance is only possible from IDLE; reset overrides it in the register block.
  assign accept = ireq & ienb & (state_q == IDLE);

  // Next-state sequencing; each wait state runs a down-counter to terminal count zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ACT;
      end
      ACT: begin
        if (T_RCD > 1) begin
          state_d = RCD_WAIT;
          cnt_d   = CNT_W'(T_RCD - 2);
        end else begin
          state_d = RD;
        end
      end
      RCD_WAIT: begin
        if (cnt_q == '0) state_d = RD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD: begin
        state_d = CAS_WAIT;
        cnt_d   = CNT_W'(CAS_LAT - 2);
      end
      CAS_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CNT_W'(BURST_LEN - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) state_d = PRE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      PRE: begin
        if (T_RP > 1) begin
          state_d = RP_WAIT;
          cnt_d   = CNT_W'(T_RP - 2);
        end else begin
          state_d = IDLE;
        end
      end
      RP_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus all registered outputs; commands are set up for the state being entered.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      bank_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fin_q   <= 1'b0;
      data_q  <= '0;
      cke_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      dqm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cke_q   <= 1'b1;
      cs_n_q  <= 1'b0;

      if (accept) begin
        col_q  <= icolumn;
        bank_q <= ibank;
      end

      case (state_d)
        ACT: begin
          cmd_q  <= CMD_ACT;
          addr_q <= irow;
          ba_q   <= ibank;
        end
        RD: begin
          cmd_q  <= CMD_RD;
          addr_q <= ROW_W'(col_q);
          ba_q   <= bank_q;
        end
        PRE: begin
          cmd_q  <= CMD_PRE;
          addr_q <= ADDR_A10;
          ba_q   <= '0;
        end
        default: begin
          cmd_q <= CMD_NOP;
        end
      endcase

      // Byte masks open from the READ cycle until the last word has left the bus.
      dqm_q <= !((state_d == RD) || (state_d == CAS_WAIT) || (state_d == DATA));

      valid_q <= (state_q == DATA);
      last_q  <= (state_q == DATA) && (cnt_q == '0);
      if (state_q == DATA) data_q <= DRAM_DQ;

      fin_q <= (state_d == IDLE) && (state_q != IDLE);
    end
  end

  assign oready     = (state_q == IDLE) & ~ireset;
  assign ovalid     = valid_q;
  assign odata      = data_q;
  assign olast      = last_q;
  assign ofin       = fin_q;
  assign DRAM_CLK   = ~iclk;
  assign DRAM_CKE   = cke_q;
  assign DRAM_ADDR  = addr_q;
  assign DRAM_BA    = ba_q;
  assign DRAM_CS_N  = cs_n_q;
  assign DRAM_RAS_N = cmd_q[2];
  assign DRAM_CAS_N = cmd_q[1];
  assign DRAM_WE_N  = cmd_q[0];
  assign DRAM_LDQM  = dqm_q;
  assign DRAM_UDQM  = dqm_q;

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: three instances (defaults; CAS3/BL8/RCD3; BL1).
// Expected commands, beats and completions are queued by the stimulus and
// consumed by a negedge monitor as the DUTs produce them.
module tb_sdram_burst_read;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic [2:0]        ireset_a, ienb_a, ireq_a;
  logic [2:0][12:0]  irow_a;
  logic [2:0][9:0]   icol_a;
  logic [2:0][1:0]   ibank_a;
  logic [2:0]        oready_a, ovalid_a, olast_a, ofin_a;
  logic [2:0][15:0]  odata_a;
  logic [2:0]        dclk_a, cke_a, cs_n_a, ras_a, cas_a, we_a, ldqm_a, udqm_a;
  logic [2:0][12:0]  addr_a;
  logic [2:0][1:0]   ba_a;
  logic [2:0][15:0]  dq_a;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdram_burst_read #(
      .CAS_LAT  (g == 1 ? 3 : 2),
      .BURST_LEN(g == 1 ? 8 : (g == 2 ? 1 : 4)),
      .T_RCD    (g == 1 ? 3 : 2)
    ) u_dut (
      .iclk      (iclk),
      .ireset    (ireset_a[g]),
      .ienb      (ienb_a[g]),
      .ireq      (ireq_a[g]),
      .irow      (irow_a[g]),
      .icolumn   (icol_a[g]),
      .ibank     (ibank_a[g]),
      .oready    (oready_a[g]),
      .ovalid    (ovalid_a[g]),
      .odata     (odata_a[g]),
      .olast     (olast_a[g]),
      .ofin      (ofin_a[g]),
      .DRAM_CLK  (dclk_a[g]),
      .DRAM_CKE  (cke_a[g]),
      .DRAM_ADDR (addr_a[g]),
      .DRAM_BA   (ba_a[g]),
      .DRAM_CS_N (cs_n_a[g]),
      .DRAM_RAS_N(ras_a[g]),
      .DRAM_CAS_N(cas_a[g]),
      .DRAM_WE_N (we_a[g]),
      .DRAM_LDQM (ldqm_a[g]),
      .DRAM_UDQM (udqm_a[g]),
      .DRAM_DQ   (dq_a[g])
    );
  end

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_PRE = 3'b010;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] cyc;
    logic [2:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] cyc;
    logic        last;
    logic [15:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] cyc;
  } fin_t;

  cmd_t  cmdq[$];
  beat_t beatq[$];
  fin_t  finq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int dqm_s[3];
  int dqm_e[3];
  int rd_at[3];
  bit rd_seen[3];
  logic [15:0] dq_base[3];

  function automatic int cas_of(int i);
    return (i == 1) ? 3 : 2;
  endfunction

  function automatic int bl_of(int i);
    return (i == 1) ? 8 : ((i == 2) ? 1 : 4);
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(string name, logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected %h expected none (t=%0t)", name, act, $time);
  endfunction

  function automatic void push_cmd(int i, int c, logic [2:0] cmd, logic [12:0] a, logic [1:0] b);
    cmd_t e;
    e.inst = 2'(i); e.cyc = 16'(c); e.cmd = cmd; e.addr = a; e.ba = b;
    cmdq.push_back(e);
  endfunction

  function automatic void push_beat(int i, int c, logic last, logic [15:0] d);
    beat_t e;
    e.inst = 2'(i); e.cyc = 16'(c); e.last = last; e.data = d;
    beatq.push_back(e);
  endfunction

  function automatic void push_fin(int i, int c);
    fin_t e;
    e.inst = 2'(i); e.cyc = 16'(c);
    finq.push_back(e);
  endfunction

  // Hand-computed relative cycles: rd = READ, beat0 = first ovalid, pre = PRECHARGE, fin = ofin.
  function automatic void expect_txn(int i, int b, logic [12:0] row, logic [9:0] col,
                                     logic [1:0] bank, logic [15:0] base,
                                     int rd, int beat0, int nb, int pre, int fin);
    push_cmd(i, b + 1, C_ACT, row, bank);
    push_cmd(i, b + rd, C_RD, 13'(col), bank);
    for (int k = 0; k < nb; k++) push_beat(i, b + beat0 + k, (k == nb - 1), base + 16'(k));
    push_cmd(i, b + pre, C_PRE, 13'h0400, 2'd0);
    push_fin(i, b + fin);
    dqm_s[i]   = b + rd;
    dqm_e[i]   = b + pre - 1;
    dq_base[i] = base;
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic start(int i, logic [12:0] row, logic [9:0] col, logic [1:0] bank);
    irow_a[i]  = row;
    icol_a[i]  = col;
    ibank_a[i] = bank;
    ireq_a[i]  = 1'b1;
  endtask

  always @(posedge iclk) cyc <= cyc + 1;

  // SDRAM read-data model: word k appears CAS_LAT+k cycles after a READ was seen.
  always @(posedge iclk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rd_seen[i] && (cyc - rd_at[i] - cas_of(i)) >= 0 &&
          (cyc - rd_at[i] - cas_of(i)) < bl_of(i))
        dq_a[i] = dq_base[i] + 16'(cyc - rd_at[i] - cas_of(i));
      else
        dq_a[i] = 16'hDEAD;
    end
  end

  // Monitor: commands, DQM window, data beats and completion pulses.
  always @(negedge iclk) begin : mon
    cmd_t  mc, ec;
    beat_t mb, eb;
    fin_t  mf, ef;
    logic  dqm_exp;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        mc.inst = 2'(i); mc.cyc = 16'(cyc); mc.cmd = {ras_a[i], cas_a[i], we_a[i]};
        mc.addr = addr_a[i]; mc.ba = ba_a[i];
        if (!cs_n_a[i] && mc.cmd != 3'b111) begin
          if (mc.cmd == C_RD) begin
            rd_at[i]   = cyc;
            rd_seen[i] = 1'b1;
          end
          if (cmdq.size() == 0) unexpected("cmd", 64'(mc));
          else begin
            ec = cmdq.pop_front();
            chk("cmd", 64'(mc), 64'(ec));
          end
        end
        dqm_exp = !(cyc >= dqm_s[i] && cyc <= dqm_e[i]);
        chk("dqm", {62'd0, ldqm_a[i], udqm_a[i]}, {62'd0, dqm_exp, dqm_exp});
        if (ovalid_a[i]) begin
          mb.inst = 2'(i); mb.cyc = 16'(cyc); mb.last = olast_a[i]; mb.data = odata_a[i];
          if (beatq.size() == 0) unexpected("beat", 64'(mb));
          else begin
            eb = beatq.pop_front();
            chk("beat", 64'(mb), 64'(eb));
          end
        end else if (olast_a[i]) begin
          unexpected("olast_without_ovalid", 64'(cyc));
        end
        if (ofin_a[i]) begin
          mf.inst = 2'(i); mf.cyc = 16'(cyc);
          if (finq.size() == 0) unexpected("ofin", 64'(mf));
          else begin
            ef = finq.pop_front();
            chk("ofin", 64'(mf), 64'(ef));
          end
        end
      end
    end
  end

  initial begin : stim
    int b;
    ireset_a = '1;
    ienb_a   = '1;
    ireq_a   = '0;
    irow_a   = '0;
    icol_a   = '0;
    ibank_a  = '0;
    dq_a     = {3{16'hDEAD}};
    for (int i = 0; i < 3; i++) begin
      dqm_s[i] = 1; dqm_e[i] = 0; rd_at[i] = 0; rd_seen[i] = 1'b0; dq_base[i] = 16'h0;
    end

    // Reset values
    step(1);
    mon_en = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++)
      chk("reset_values",
          64'({ovalid_a[i], olast_a[i], ofin_a[i], odata_a[i], cke_a[i], cs_n_a[i],
               ras_a[i], cas_a[i], we_a[i], addr_a[i], ba_a[i], ldqm_a[i], udqm_a[i],
               oready_a[i], dclk_a[i]}),
          64'({1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 13'h0, 2'h0,
               1'b1, 1'b1, 1'b0, 1'b0}));
    ireset_a = '0;
    step(1);
    for (int i = 0; i < 3; i++)
      chk("post_reset", 64'({cke_a[i], cs_n_a[i], oready_a[i], ras_a[i], cas_a[i], we_a[i]}),
          64'({1'b1, 1'b0, 1'b1, 3'b111}));
    step(2);

    // Default burst: row 5, col 4, bank 1
    b = cyc;
    expect_txn(0, b, 13'h0005, 10'h004, 2'd1, 16'h1000, 3, 6, 4, 9, 11);
    start(0, 13'h0005, 10'h004, 2'd1);
    step(1);
    ireq_a[0] = 1'b0;
    chk("busy_not_ready", 64'(oready_a[0]), 64'd0);
    step(13);

    // CAS_LAT=3, BURST_LEN=8, T_RCD=3; column at its maximum
    b = cyc;
    expect_txn(1, b, 13'h1ABC, 10'h3FF, 2'd2, 16'h5A00, 4, 8, 8, 15, 17);
    start(1, 13'h1ABC, 10'h3FF, 2'd2);
    step(1);
    ireq_a[1] = 1'b0;
    step(19);

    // BURST_LEN=1
    b = cyc;
    expect_txn(2, b, 13'h0777, 10'h021, 2'd3, 16'h7700, 3, 6, 1, 6, 8);
    start(2, 13'h0777, 10'h021, 2'd3);
    step(1);
    ireq_a[2] = 1'b0;
    step(10);

    // ireq held high across two transactions; address changes while busy
    b = cyc;
    expect_txn(0, b, 13'h0123, 10'h010, 2'd3, 16'h2000, 3, 6, 4, 9, 11);
    start(0, 13'h0123, 10'h010, 2'd3);
    step(5);
    irow_a[0] = 13'h1FFF; icol_a[0] = 10'h2AA; ibank_a[0] = 2'd0;
    step(6);
    chk("ready_at_fin", 64'(oready_a[0]), 64'd1);
    expect_txn(0, cyc, 13'h1FFF, 10'h2AA, 2'd0, 16'h3000, 3, 6, 4, 9, 11);
    step(1);
    ireq_a[0] = 1'b0;
    step(13);

    // ienb low with ireq high: never accepted
    ienb_a[0] = 1'b0;
    ireq_a[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("enb_low_ready", 64'(oready_a[0]), 64'd1);
      step(1);
    end
    ireq_a[0] = 1'b0;
    ienb_a[0] = 1'b1;
    step(2);

    // ienb dropped in cycle 4 of an accepted transaction
    b = cyc;
    expect_txn(0, b, 13'h0A0A, 10'h155, 2'd2, 16'h4000, 3, 6, 4, 9, 11);
    start(0, 13'h0A0A, 10'h155, 2'd2);
    step(1);
    ireq_a[0] = 1'b0;
    step(3);
    ienb_a[0] = 1'b0;
    step(9);
    ienb_a[0] = 1'b1;
    step(2);

    // Reset asserted in cycle 7: two beats only, no PRECHARGE, no ofin
    b = cyc;
    push_cmd(0, b + 1, C_ACT, 13'h0005, 2'd1);
    push_cmd(0, b + 3, C_RD, 13'h0004, 2'd1);
    push_beat(0, b + 6, 1'b0, 16'h1000);
    push_beat(0, b + 7, 1'b0, 16'h1001);
    dqm_s[0] = b + 3; dqm_e[0] = b + 7; dq_base[0] = 16'h1000;
    start(0, 13'h0005, 10'h004, 2'd1);
    step(1);
    ireq_a[0] = 1'b0;
    step(6);
    ireset_a[0] = 1'b1;
    step(1);
    chk("reset_mid_c8", 64'({ovalid_a[0], cke_a[0], cs_n_a[0], oready_a[0]}), 64'(4'b0010));
    step(1);
    chk("reset_mid_c9", 64'({ovalid_a[0], cke_a[0], cs_n_a[0], oready_a[0], ofin_a[0]}),
        64'(5'b00100));
    ireset_a[0] = 1'b0;
    step(1);
    b = cyc;
    expect_txn(0, b, 13'h0066, 10'h033, 2'd1, 16'h6000, 3, 6, 4, 9, 11);
    start(0, 13'h0066, 10'h033, 2'd1);
    step(1);
    ireq_a[0] = 1'b0;
    step(14);

    chk("cmd_queue_drained", 64'(cmdq.size()), 64'd0);
    chk("beat_queue_drained", 64'(beatq.size()), 64'd0);
    chk("fin_queue_drained", 64'(finq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
